// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared defaults, FSM state type and fifo_wdata field layout for the FIFO
// write-port arbiter. The source ID occupies the MSBs of fifo_wdata.
package fifo_wr_arbiter_pkg;

  localparam int NREQ_DEF      = 4;
  localparam int DSIZE_DEF     = 8;
  localparam int MAX_BURST_DEF = 4;
  localparam int IDW_DEF       = $clog2(NREQ_DEF);

  localparam int WDATA_W_DEF   = IDW_DEF + DSIZE_DEF;
  localparam int ID_MSB_DEF    = WDATA_W_DEF - 1;
  localparam int ID_LSB_DEF    = DSIZE_DEF;
  localparam int PAY_MSB_DEF   = DSIZE_DEF - 1;
  localparam int PAY_LSB_DEF   = 0;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } arb_state_e;

  function automatic int burst_cnt_width(input int max_burst);
    return $clog2(max_burst + 1);
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational rotate-priority encoder: first asserted request searching
// upward from last_owner+1, wrapping; last_owner itself has lowest priority.
module fifo_wr_arbiter_rr_pick
  import fifo_wr_arbiter_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  last_owner,
  output logic [NREQ-1:0] onehot,
  output logic [IDW-1:0]  idx,
  output logic            valid
);

  always_comb begin
    logic [IDW-1:0] cand;
    cand   = '0;
    idx    = '0;
    valid  = 1'b0;
    // Walk from farthest to nearest so the nearest hit is written last;
    // k == NREQ truncates to last_owner itself.
    for (int k = NREQ; k >= 1; k--) begin
      cand = last_owner + IDW'(k);
      if (req[cand]) begin
        idx   = cand;
        valid = 1'b1;
      end
    end
    onehot = valid ? (NREQ'(1) << idx) : '0;
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter feeding NREQ requesters into one async-FIFO
// write port; each grant allows up to MAX_BURST writes, tagged with the source ID.
module fifo_wr_arbiter
  import fifo_wr_arbiter_pkg::*;
#(
  parameter int DSIZE     = DSIZE_DEF,
  parameter int NREQ      = NREQ_DEF,
  parameter int MAX_BURST = MAX_BURST_DEF
) (
  input  logic                           wclk,
  input  logic                           wrst_n,
  input  logic [NREQ-1:0]                req,
  input  logic [NREQ*DSIZE-1:0]          req_data,
  output logic [NREQ-1:0]                ack,
  output logic [NREQ-1:0]                grant,
  output logic [$clog2(NREQ)+DSIZE-1:0]  fifo_wdata,
  output logic                           fifo_w_en,
  input  logic                           fifo_wfull
);

  localparam int IDW = $clog2(NREQ);
  localparam int CW  = burst_cnt_width(MAX_BURST);

  arb_state_e      state_q, state_d;
  logic [NREQ-1:0] grant_q, grant_d;
  logic [IDW-1:0]  gidx_q, gidx_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [IDW-1:0]  last_q, last_d;

  logic [NREQ-1:0] pick_oh;
  logic [IDW-1:0]  pick_idx;
  logic            pick_valid;
  logic            req_g;
  logic [DSIZE-1:0] payload;
  logic            wr;
  logic [CW-1:0]   cnt_inc;

  fifo_wr_arbiter_rr_pick #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) rr_pick (
    .req        (req),
    .last_owner (last_q),
    .onehot     (pick_oh),
    .idx        (pick_idx),
    .valid      (pick_valid)
  );

  always_comb begin
    payload = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gidx_q == IDW'(i)) payload = req_data[i*DSIZE +: DSIZE];
    end
  end

  assign req_g   = req[gidx_q];
  assign wr      = (state_q == ST_BURST) && req_g && !fifo_wfull;
  assign cnt_inc = cnt_q + CW'(1);

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    gidx_d  = gidx_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    unique case (state_q)
      ST_IDLE: begin
        if (pick_valid) begin
          grant_d = pick_oh;
          gidx_d  = pick_idx;
          cnt_d   = '0;
          state_d = ST_BURST;
        end
      end
      ST_BURST: begin
        // A dropped request ends the burst even while the FIFO is full.
        if (!req_g || (wr && (cnt_inc == CW'(MAX_BURST)))) begin
          state_d = ST_IDLE;
          grant_d = '0;
          cnt_d   = '0;
          last_d  = gidx_q;
        end else if (wr) begin
          cnt_d = cnt_inc;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      gidx_q  <= '0;
      cnt_q   <= '0;
      last_q  <= IDW'(NREQ - 1);
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      gidx_q  <= gidx_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
    end
  end

  assign grant      = grant_q;
  assign fifo_w_en  = wr;
  assign ack        = wr ? grant_q : '0;
  assign fifo_wdata = (state_q == ST_BURST) ? {gidx_q, payload} : '0;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: reference-model scoreboard, a vector table for
// the single-requester case and directed sequences for stalls, drops and reset.
module tb_fifo_wr_arbiter;

  localparam int NREQ = 4;
  localparam int DSIZE = 8;
  localparam int MAXB = 4;

  typedef struct packed {
    logic [3:0] grant;
    logic [3:0] ack;
    logic       wen;
    logic [9:0] wdata;
  } out_t;

  typedef struct {
    logic [3:0] req;
    logic       wf;
    out_t       exp;
  } vec_t;

  logic        wclk;
  logic        wrst_n;
  logic [3:0]  req;
  logic [31:0] req_data;
  logic [3:0]  ack;
  logic [3:0]  grant;
  logic [9:0]  fifo_wdata;
  logic        fifo_w_en;
  logic        fifo_wfull;

  logic [7:0] pay [4];

  int n_tests = 0;
  int n_fail  = 0;

  out_t exp_q[$];

  int m_busy, m_owner, m_cnt, m_last;

  fifo_wr_arbiter #(
    .DSIZE     (DSIZE),
    .NREQ      (NREQ),
    .MAX_BURST (MAXB)
  ) dut (
    .wclk       (wclk),
    .wrst_n     (wrst_n),
    .req        (req),
    .req_data   (req_data),
    .ack        (ack),
    .grant      (grant),
    .fifo_wdata (fifo_wdata),
    .fifo_w_en  (fifo_w_en),
    .fifo_wfull (fifo_wfull)
  );

  initial wclk = 1'b0;
  always #5 wclk = ~wclk;

  task automatic check_out(input string name, input out_t got, input out_t exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got grant=%b ack=%b wen=%b wdata=%h, expected grant=%b ack=%b wen=%b wdata=%h",
               name, got.grant, got.ack, got.wen, got.wdata,
               exp.grant, exp.ack, exp.wen, exp.wdata);
    end
  endtask

  task automatic check_int(input string name, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  function automatic out_t mk(input logic [3:0] g, input logic [3:0] a,
                              input logic w, input logic [9:0] d);
    out_t o;
    o.grant = g; o.ack = a; o.wen = w; o.wdata = d;
    return o;
  endfunction

  function automatic void model_reset();
    m_busy = 0; m_owner = 0; m_cnt = 0; m_last = NREQ - 1;
  endfunction

  function automatic out_t model_out(input logic [3:0] r, input logic wf);
    out_t o;
    o = '0;
    if (m_busy != 0) begin
      o.grant = 4'b0001 << m_owner;
      o.wdata = {2'(m_owner), pay[m_owner]};
      if (r[m_owner] && !wf) begin
        o.wen = 1'b1;
        o.ack = o.grant;
      end
    end
    return o;
  endfunction

  function automatic void model_update(input logic [3:0] r, input logic wf);
    bit found;
    if (m_busy == 0) begin
      found = 0;
      for (int k = 1; k <= NREQ; k++) begin
        int c;
        c = (m_last + k) % NREQ;
        if (!found && r[c]) begin
          found = 1; m_owner = c;
        end
      end
      if (found) begin
        m_busy = 1; m_cnt = 0;
      end
    end else if (!r[m_owner]) begin
      m_busy = 0; m_last = m_owner;
    end else if (!wf) begin
      m_cnt++;
      if (m_cnt == MAXB) begin
        m_busy = 0; m_last = m_owner;
      end
    end
  endfunction

  // One clock: drive at posedge+1, compare at negedge, advance model.
  task automatic step(input logic [3:0] r, input logic wf, output out_t got);
    out_t e;
    req = r;
    fifo_wfull = wf;
    exp_q.push_back(model_out(r, wf));
    @(negedge wclk);
    got = {grant, ack, fifo_w_en, fifo_wdata};
    e = exp_q.pop_front();
    check_out("scoreboard", got, e);
    model_update(r, wf);
    @(posedge wclk);
    #1;
  endtask

  task automatic do_reset();
    wrst_n = 1'b0;
    req = '0;
    fifo_wfull = 1'b0;
    model_reset();
    exp_q.delete();
    @(posedge wclk);
    #1;
    wrst_n = 1'b1;
  endtask

  initial begin
    vec_t tbl [7];
    out_t got;
    int   starts[$];
    int   bw[$];
    int   writes;
    int   stall_acks;
    logic [3:0] prev_grant;
    logic [3:0] r;
    logic       wf;
    int   wait_cnt [4];
    int   cur_bw;

    tbl[0] = '{req: 4'b0001, wf: 1'b0, exp: mk(4'b0000, 4'b0000, 1'b0, 10'h000)};
    tbl[1] = '{req: 4'b0001, wf: 1'b0, exp: mk(4'b0001, 4'b0001, 1'b1, 10'h0A5)};
    tbl[2] = '{req: 4'b0001, wf: 1'b0, exp: mk(4'b0001, 4'b0001, 1'b1, 10'h0A5)};
    tbl[3] = '{req: 4'b0001, wf: 1'b0, exp: mk(4'b0001, 4'b0001, 1'b1, 10'h0A5)};
    tbl[4] = '{req: 4'b0001, wf: 1'b0, exp: mk(4'b0001, 4'b0001, 1'b1, 10'h0A5)};
    tbl[5] = '{req: 4'b0001, wf: 1'b0, exp: mk(4'b0000, 4'b0000, 1'b0, 10'h000)};
    tbl[6] = '{req: 4'b0001, wf: 1'b0, exp: mk(4'b0001, 4'b0001, 1'b1, 10'h0A5)};

    pay[0] = 8'hA5; pay[1] = 8'hB1; pay[2] = 8'hC2; pay[3] = 8'hD3;
    req_data = {pay[3], pay[2], pay[1], pay[0]};

    // Reset state with every requester active
    wrst_n = 1'b0;
    req = 4'b1111;
    fifo_wfull = 1'b0;
    model_reset();
    @(posedge wclk);
    #1;
    check_out("reset_outputs", {grant, ack, fifo_w_en, fifo_wdata}, '0);
    wrst_n = 1'b1;

    // Single requester, full bursts
    for (int i = 0; i < 7; i++) begin
      step(tbl[i].req, tbl[i].wf, got);
      check_out($sformatf("vec%0d", i), got, tbl[i].exp);
    end

    // All requesters: rotation 0,1,2,3,0
    do_reset();
    prev_grant = '0;
    for (int c = 0; c < 25; c++) begin
      step(4'b1111, 1'b0, got);
      if (prev_grant == 0 && got.grant != 0) begin
        starts.push_back($clog2(int'(got.grant)));
        bw.push_back(0);
      end
      if (got.wen && bw.size() > 0) bw[bw.size()-1]++;
      prev_grant = got.grant;
    end
    check_int("rotation_bursts", starts.size(), 5);
    for (int i = 0; i < starts.size() && i < 5; i++) begin
      check_int($sformatf("rotation_owner%0d", i), starts[i], i % NREQ);
      check_int($sformatf("rotation_len%0d", i), bw[i], MAXB);
    end

    // Owner 2 stalled by full FIFO for 3 cycles
    do_reset();
    writes = 0;
    stall_acks = 0;
    for (int c = 0; c < 9; c++) begin
      wf = (c >= 3 && c <= 5);
      step(4'b0100, wf, got);
      if (got.wen) writes++;
      if (wf && (got.ack != 0 || got.wen)) stall_acks++;
      if (c == 1) check_int("stall_owner", int'(got.grant), 4);
      if (c == 8) check_int("stall_idle_after", int'(got.grant), 0);
    end
    check_int("stall_no_ack", stall_acks, 0);
    check_int("stall_total_writes", writes, MAXB);

    // Owner 1 drops after 2 writes, requester 3 waiting
    do_reset();
    writes = 0;
    for (int c = 0; c < 7; c++) begin
      r = (c < 3) ? 4'b1010 : 4'b1000;
      step(r, 1'b0, got);
      if (c >= 1 && c <= 3 && got.wen) writes++;
      if (c == 3) check_int("drop_no_write", int'(got.wen), 0);
      if (c == 5) check_int("drop_next_grant", int'(got.grant), 8);
    end
    check_int("drop_writes", writes, 2);

    // Asynchronous reset in the middle of owner 3's burst
    wrst_n = 1'b0;
    #1;
    check_out("async_reset_outputs", {grant, ack, fifo_w_en, fifo_wdata}, '0);
    model_reset();
    exp_q.delete();
    @(posedge wclk);
    #1;
    wrst_n = 1'b1;
    step(4'b1000, 1'b0, got);
    step(4'b1000, 1'b0, got);
    check_int("post_reset_grant", int'(got.grant), 8);

    // Random traffic with protocol-respecting requesters
    do_reset();
    r = '0;
    prev_grant = '0;
    cur_bw = 0;
    for (int i = 0; i < 4; i++) wait_cnt[i] = 0;
    for (int c = 0; c < 10000; c++) begin
      wf = ($urandom_range(3) == 0);
      step(r, wf, got);
      for (int i = 0; i < 4; i++) if (!r[i]) wait_cnt[i] = 0;
      if (prev_grant == 0 && got.grant != 0) begin
        cur_bw = 0;
        for (int i = 0; i < 4; i++) begin
          if (got.grant[i]) wait_cnt[i] = 0;
          else if (r[i]) begin
            wait_cnt[i]++;
            if (wait_cnt[i] > NREQ - 1)
              check_int($sformatf("starvation_req%0d", i), wait_cnt[i], NREQ - 1);
          end
        end
      end
      if ($countones(got.ack) > 1) check_int("ack_onehot", $countones(got.ack), 1);
      check_int("ack_vs_wen", int'(got.ack != 0), int'(got.wen));
      if (got.wen) begin
        cur_bw++;
        check_int("burst_len_ok", int'(cur_bw <= MAXB), 1);
      end
      prev_grant = got.grant;
      for (int i = 0; i < 4; i++) begin
        if (r[i] && !got.ack[i]) r[i] = ($urandom_range(15) != 0);
        else r[i] = ($urandom_range(1) == 1);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fifo_wr_arbiter.md
FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 Parameter DSIZE, default 8: payload width per requester.
REQ-002 Parameter NREQ, default 4: number of requesters; power of two, ≥2.
REQ-003 Parameter MAX_BURST, default 4: maximum writes per grant; ≥1.
REQ-004 Derived constant IDW = log2(NREQ): source-ID width.
REQ-005 wclk  input  1  write-domain clock; all state updates on rising edge.
REQ-006 wrst_n  input  1  reset, asynchronous, active-low.
REQ-007 req  input  NREQ  per-requester "word available"; held until acked.
REQ-008 req_data  input  NREQ*DSIZE  flattened payloads; slice i = [i*DSIZE +: DSIZE].
REQ-009 ack  output  NREQ  one-hot pop strobe; requester i consumes its word when ack[i]=1.
REQ-010 grant  output  NREQ  one-hot registered current owner; all-zero when idle.
REQ-011 fifo_wdata  output  IDW+DSIZE  {source ID, payload} to async FIFO write port.
REQ-012 fifo_w_en  output  1  FIFO write enable.
REQ-013 fifo_wfull  input  1  FIFO full flag, already synchronous to wclk.

Function
REQ-014 FSM has two states, IDLE and BURST; state, grant, burst count and last-owner pointer are registers.
REQ-015 IDLE: if req is nonzero, select the first asserted requester searching upward from (last_owner+1) mod NREQ with wrap; load grant, clear burst count, enter BURST next cycle.
REQ-016 IDLE: if req is zero, stay in IDLE; grant=0, ack=0, fifo_w_en=0.
REQ-017 BURST: fifo_w_en = req[g] AND NOT fifo_wfull, combinational, where g is the granted index.
REQ-018 ack[g] equals fifo_w_en; all other ack bits are 0; ack is never asserted in IDLE.
REQ-019 fifo_wdata = {g, req_data slice g} whenever BURST; all zeros in IDLE.
REQ-020 Each write increments burst count (width ceil(log2(MAX_BURST+1))).
REQ-021 BURST exits to IDLE after the write that makes count equal MAX_BURST, or on any cycle where req[g]=0; on exit last_owner←g and grant←0.
REQ-022 fifo_wfull=1 in BURST stalls: no write, no ack, count held, state held; no timeout.
REQ-023 req[g] falling during a full stall exits to IDLE per REQ-021 with no write.
REQ-024 Latency: req rising in IDLE → first fifo_w_en two edges later at earliest (one IDLE decision cycle, write in first BURST cycle).
REQ-025 Back-to-back bursts always pass through one IDLE cycle; peak throughput MAX_BURST/(MAX_BURST+1).
REQ-026 Requests from non-granted requesters never affect the current burst.
REQ-027 Fairness: any requester holding req continuously is granted within NREQ-1 other bursts.

Reset
REQ-028 wrst_n low asynchronously forces IDLE, grant=0, burst count=0, last_owner=NREQ-1 (so requester 0 wins first).
REQ-029 During reset ack=0, fifo_w_en=0, fifo_wdata=0.
REQ-030 Reset mid-burst abandons the burst; no partial-write state survives; first decision occurs on the first rising edge after deassertion.

Structure
REQ-031 Shared package holds NREQ, DSIZE, MAX_BURST defaults, IDW and the fifo_wdata field-layout constants (ID MSB-aligned).
REQ-032 One sub-module, rr_pick: purely combinational rotate-priority encoder (inputs req and last_owner, outputs one-hot and index, plus a valid bit).
REQ-033 No clock-domain crossing inside this block; the FIFO owns synchronisation.

Verification
REQ-034 Reset, then req=4'b0001 held with data 8'hA5, wfull=0 → writes of 10'h0A5 on 4 consecutive cycles, then one IDLE cycle, then grant again to 0.
REQ-035 req=4'b1111 continuously → grant order 0,1,2,3,0, each burst 4 writes, ID field matches owner.
REQ-036 Owner 2 mid-burst, wfull=1 for 3 cycles → no ack/w_en during the stall, count preserved, burst completes with exactly 4 total writes.
REQ-037 Owner 1 drops req after 2 writes while req[3]=1 → exit to IDLE, next grant 3, last_owner=1.
REQ-038 wrst_n pulsed low mid-burst (owner 3) → outputs zero immediately; after release with req=4'b1000, grant goes to 3 (search begins at 0, finds 3).
REQ-039 Random req/wfull for 10k cycles → scoreboard: every ack matches exactly one FIFO write, ≤1 ack bit active, burst ≤ MAX_BURST, no starvation beyond NREQ-1 bursts.
